// File: rtl/counter_ctrl_if.sv
// Control/status bundle for counter_ctrl: run controls in, count and status out.
interface counter_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] limit;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             done;
   logic [1:0]       state;

   // Controller side: drives the run controls, observes count and status.
   modport master (
      output start, pause, abort, limit, auto_reload,
      input  count, busy, tc, done, state
   );

   // Counter side: receives the run controls, produces count and status.
   modport slave (
      input  start, pause, abort, limit, auto_reload,
      output count, busy, tc, done, state
   );
endinterface

// File: rtl/counter_ctrl.sv
// Run-controlled up-counter with a terminal count, optional periodic reload,
// pause and abort. Limit and mode are captured on an accepted start.
module counter_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   counter_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t           st;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] lim;
   logic             reload;
   logic             tc_r;
   logic             done_r;

   // State, count, latched settings and event pulses; priority rst > abort > start > pause > advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         cnt    <= '0;
         lim    <= '0;
         reload <= 1'b0;
         tc_r   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         tc_r   <= 1'b0;
         done_r <= 1'b0;
         if (bus.abort) begin
            st  <= IDLE;
            cnt <= '0;
         end else if (bus.start && (st == IDLE || st == DONE)) begin
            lim    <= bus.limit;
            reload <= bus.auto_reload;
            cnt    <= '0;
            st     <= RUN;
         end else begin
            case (st)
               RUN: begin
                  if (bus.pause) begin
                     st <= PAUSED;
                  end else if (cnt == lim) begin
                     // Terminal count: wrap to zero when periodic, otherwise park at the limit.
                     tc_r <= 1'b1;
                     if (reload) begin
                        cnt <= '0;
                     end else begin
                        done_r <= 1'b1;
                        st     <= DONE;
                     end
                  end else begin
                     cnt <= cnt + WIDTH'(1);
                  end
               end
               PAUSED: begin
                  // Resume edge only changes state; counting restarts on the following edge.
                  if (!bus.pause) begin
                     st <= RUN;
                  end
               end
               IDLE: begin
                  cnt <= '0;
               end
               default: begin
                  st <= DONE;
               end
            endcase
         end
      end
   end

   assign bus.count = cnt;
   assign bus.state = st;
   assign bus.busy  = (st == RUN) || (st == PAUSED);
   assign bus.tc    = tc_r;
   assign bus.done  = done_r;

endmodule
